// File: rtl/regfile_param_clr.sv
// Parametrised two-read/one-write register file with optional zero register,
// optional write-to-read bypass, a sequential bulk-clear sweep and a write-error pulse.
module regfile_param_clr #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 3,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic              WE3,
    input  logic [WIDTH-1:0]  WD3,
    input  logic              CLR,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2,
    output logic              BUSY,
    output logic              DONE,
    output logic              WERR
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // One extra bit so DEPTH == 2**ADDR_W is representable
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

    logic [WIDTH-1:0]  mem_r [DEPTH];
    state_t            state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic              busy_r;
    logic              done_r;
    logic              werr_r;

    logic              a3_in_range_s;
    logic              we_ok_s;
    logic              werr_s;
    logic [WIDTH-1:0]  rd1_stored_s;
    logic [WIDTH-1:0]  rd2_stored_s;

    // Read-port priority: out of range, then zero register, then bypass, then storage
    function automatic logic [WIDTH-1:0] read_sel(
        input logic [ADDR_W-1:0] addr,
        input logic [WIDTH-1:0]  stored,
        input logic              we_ok,
        input logic [ADDR_W-1:0] waddr,
        input logic [WIDTH-1:0]  wdata
    );
        logic [WIDTH-1:0] v;
        if ({1'b0, addr} >= DEPTH_W) begin
            v = '0;
        end else if ((ZERO_REG != 0) && (addr == ZERO_ADDR)) begin
            v = '0;
        end else if ((BYPASS != 0) && we_ok && (addr == waddr)) begin
            v = wdata;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    // Write acceptance and rejection decode
    always_comb begin
        a3_in_range_s = ({1'b0, A3} < DEPTH_W);
        if (WE3 && (state_r == IDLE) && a3_in_range_s &&
            !((ZERO_REG != 0) && (A3 == ZERO_ADDR))) begin
            we_ok_s = 1'b1;
        end else begin
            we_ok_s = 1'b0;
        end
        if (WE3 && ((state_r == CLEAR) || !a3_in_range_s)) begin
            werr_s = 1'b1;
        end else begin
            werr_s = 1'b0;
        end
    end

    // Guarded array fetch so an out-of-range address never indexes past the array
    always_comb begin
        if ({1'b0, A1} < DEPTH_W) begin
            rd1_stored_s = mem_r[A1];
        end else begin
            rd1_stored_s = '0;
        end
        if ({1'b0, A2} < DEPTH_W) begin
            rd2_stored_s = mem_r[A2];
        end else begin
            rd2_stored_s = '0;
        end
    end

    assign RD1  = read_sel(A1, rd1_stored_s, we_ok_s, A3, WD3);
    assign RD2  = read_sel(A2, rd2_stored_s, we_ok_s, A3, WD3);
    assign BUSY = busy_r;
    assign DONE = done_r;
    assign WERR = werr_r;

    // Register array, clear-sweep FSM and status pulses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            state_r <= IDLE;
            ptr_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            werr_r  <= 1'b0;
        end else begin
            werr_r <= werr_s;
            done_r <= 1'b0;
            // A write accepted on the CLR edge still lands; the sweep removes it later
            if (we_ok_s) begin
                mem_r[A3] <= WD3;
            end
            case (state_r)
                IDLE: begin
                    if (CLR) begin
                        state_r <= CLEAR;
                        ptr_r   <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                CLEAR: begin
                    mem_r[ptr_r] <= '0;
                    if (ptr_r == LAST_PTR) begin
                        state_r <= IDLE;
                        ptr_r   <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        ptr_r   <= ptr_r + ADDR_W'(1);
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ptr_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_param_clr.sv
// Self-checking bench: a DEPTH=8 and a DEPTH=6 instance share stimulus and are
// compared every cycle against an array-based reference model.
module tb_regfile_param_clr;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        WE3 = 1'b0;
    logic        CLR = 1'b0;
    logic [2:0]  A1 = 3'd0, A2 = 3'd0, A3 = 3'd0;
    logic [31:0] WD3 = 32'd0;

    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        busy_a, done_a, werr_a, busy_b, done_b, werr_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    regfile_param_clr #(.WIDTH(32), .ADDR_W(3), .DEPTH(8), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .A3(A3), .WE3(WE3), .WD3(WD3), .CLR(CLR),
        .RD1(rd1_a), .RD2(rd2_a), .BUSY(busy_a), .DONE(done_a), .WERR(werr_a));

    regfile_param_clr #(.WIDTH(32), .ADDR_W(3), .DEPTH(6), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .A3(A3), .WE3(WE3), .WD3(WD3), .CLR(CLR),
        .RD1(rd1_b), .RD2(rd2_b), .BUSY(busy_b), .DONE(done_b), .WERR(werr_b));

    // Reference model, index 0 = DEPTH 8, index 1 = DEPTH 6
    logic [31:0] mem [2][8];
    bit          m_sweep [2];
    int          m_left  [2];
    int          m_next  [2];
    bit          m_done  [2];
    bit          m_werr  [2];
    int          dep     [2] = '{8, 6};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit accepted(int k);
        return WE3 && !m_sweep[k] && (int'(A3) < dep[k]) && (A3 != 3'd0);
    endfunction

    function automatic logic [31:0] mread(int k, logic [2:0] a);
        if (int'(a) >= dep[k]) return 32'd0;
        if (a == 3'd0) return 32'd0;
        if (accepted(k) && a == A3) return WD3;
        return mem[k][a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) mem[k][i] = 32'd0;
            m_sweep[k] = 1'b0; m_left[k] = 0; m_next[k] = 0;
            m_done[k] = 1'b0; m_werr[k] = 1'b0;
        end
    endtask

    // Effect of one rising edge: sweep zeroes registers lowest-first, one per edge
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit acc;
            acc = accepted(k);
            m_werr[k] = WE3 && (m_sweep[k] || int'(A3) >= dep[k]);
            if (acc) mem[k][A3] = WD3;
            m_done[k] = 1'b0;
            if (m_sweep[k]) begin
                mem[k][m_next[k]] = 32'd0;
                m_next[k]++;
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_sweep[k] = 1'b0;
                    m_done[k] = 1'b1;
                end
            end else if (CLR) begin
                m_sweep[k] = 1'b1;
                m_left[k] = dep[k];
                m_next[k] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rd1_d8"}, rd1_a, mread(0, A1));
        check({tag, ".rd2_d8"}, rd2_a, mread(0, A2));
        check({tag, ".busy_d8"}, {31'd0, busy_a}, {31'd0, m_sweep[0]});
        check({tag, ".done_d8"}, {31'd0, done_a}, {31'd0, m_done[0]});
        check({tag, ".werr_d8"}, {31'd0, werr_a}, {31'd0, m_werr[0]});
        check({tag, ".rd1_d6"}, rd1_b, mread(1, A1));
        check({tag, ".rd2_d6"}, rd2_b, mread(1, A2));
        check({tag, ".busy_d6"}, {31'd0, busy_b}, {31'd0, m_sweep[1]});
        check({tag, ".done_d6"}, {31'd0, done_b}, {31'd0, m_done[1]});
        check({tag, ".werr_d6"}, {31'd0, werr_b}, {31'd0, m_werr[1]});
    endtask

    // Called in the low clock phase: apply inputs, check, take one edge
    task automatic drive(input string tag, input logic we, input logic [2:0] a3,
                         input logic [31:0] wd, input logic [2:0] a1,
                         input logic [2:0] a2, input logic clr);
        WE3 = we; A3 = a3; WD3 = wd; A1 = a1; A2 = a2; CLR = clr;
        #1;
        check_all(tag);
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    // Asynchronous reset pulse entirely inside the low phase, no clock edge
    task automatic do_reset(input string tag);
        RST = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1;
        RST = 1'b0;
        #1;
    endtask

    int busy_cnt, done_cnt;

    initial begin
        model_reset();
        @(negedge CLK);
        do_reset("reset");

        // Bypass then stored read-back
        WE3 = 1'b1; A3 = 3'd5; WD3 = 32'hDEADBEEF; A1 = 3'd5; A2 = 3'd0; CLR = 1'b0;
        #1;
        check("bypass_const", rd1_a, 32'hDEADBEEF);
        drive("bypass", 1'b1, 3'd5, 32'hDEADBEEF, 3'd5, 3'd0, 1'b0);
        drive("stored", 1'b0, 3'd0, 32'd0, 3'd5, 3'd5, 1'b0);

        // Zero register
        drive("zero_wr", 1'b1, 3'd0, 32'h1234, 3'd0, 3'd0, 1'b0);
        drive("zero_rd", 1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 1'b0);
        check("zero_werr_const", {31'd0, werr_a}, 32'd0);

        // Out of range for the DEPTH 6 instance
        drive("oor_wr", 1'b1, 3'd7, 32'hCAFEF00D, 3'd7, 3'd7, 1'b0);
        check("oor_werr_d6_const", {31'd0, werr_b}, 32'd1);
        check("oor_rd_d6_const", rd2_b, 32'd0);
        drive("oor_after", 1'b0, 3'd0, 32'd0, 3'd7, 3'd7, 1'b0);

        // Bulk clear with a rejected write at the second sweep edge
        for (int i = 1; i < 8; i++)
            drive("fill", 1'b1, 3'(i), 32'h11 * i, 3'(i), 3'd7, 1'b0);
        drive("clr_req", 1'b0, 3'd0, 32'd0, 3'd7, 3'd3, 1'b1);
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            busy_cnt += int'(busy_a);
            done_cnt += int'(done_a);
            drive("sweep", (c == 1), 3'd3, 32'hBAD0BAD0, 3'd7, 3'd3, 1'b0);
        end
        check("sweep_busy_cycles", 32'(busy_cnt), 32'd8);
        check("sweep_done_pulses", 32'(done_cnt), 32'd1);
        for (int i = 0; i < 8; i++)
            drive("post_clear", 1'b0, 3'd0, 32'd0, 3'(i), 3'(7 - i), 1'b0);

        // Reset mid-sweep, then a full sweep
        for (int i = 1; i < 8; i++)
            drive("refill", 1'b1, 3'(i), 32'h01010101 * i, 3'(i), 3'd0, 1'b0);
        drive("clr2", 1'b0, 3'd0, 32'd0, 3'd6, 3'd7, 1'b1);
        for (int c = 0; c < 3; c++)
            drive("part_sweep", 1'b0, 3'd0, 32'd0, 3'd6, 3'd7, 1'b0);
        do_reset("mid_reset");
        check("mid_reset_busy_const", {31'd0, busy_a}, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            done_cnt += int'(done_a);
            drive("after_abort", 1'b0, 3'd0, 32'd0, 3'(i), 3'(i), 1'b0);
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        drive("clr3", 1'b0, 3'd0, 32'd0, 3'd1, 3'd2, 1'b1);
        busy_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            busy_cnt += int'(busy_a);
            drive("full_sweep", 1'b0, 3'd0, 32'd0, 3'd1, 3'd2, 1'b0);
        end
        check("full_sweep_busy_cycles", 32'(busy_cnt), 32'd8);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_reset");
            end
            drive("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 29) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
